// File: rtl/led_pkg.sv
// -----------------------------------------------------------------------------
// led_pkg
// Shared definitions for the multi-channel LED PWM dimmer (led_pwm_array).
//   - MODE_AUTO / MODE_MANUAL : mode input encodings (anything else is off)
//   - ch_state_e              : per-channel ramp state
//   - level_to_duty           : manual level (0..9) to duty, level*period/9
//   - sat_add / sat_sub       : ramp arithmetic clamped to a ceiling/floor
// Targets and ramp sums use TGT_W (17) bits so intermediate values never wrap.
// -----------------------------------------------------------------------------
package led_pkg;

   localparam logic [3:0]  MODE_AUTO   = 4'b0001;
   localparam logic [3:0]  MODE_MANUAL = 4'b0010;
   localparam int unsigned TGT_W       = 17;

   typedef enum logic [1:0] {
      CH_IDLE = 2'd0,
      CH_UP   = 2'd1,
      CH_DOWN = 2'd2,
      CH_HOLD = 2'd3
   } ch_state_e;

   // Manual brightness table entry; evaluated on constants only.
   function automatic logic [TGT_W-1:0] level_to_duty(input int unsigned level,
                                                      input int unsigned period);
      int unsigned prod;
      prod = (level * period) / 32'd9;
      return TGT_W'(prod);
   endfunction

   // a + b, never above ceil.
   function automatic logic [TGT_W-1:0] sat_add(input logic [TGT_W-1:0] a,
                                                input logic [TGT_W-1:0] b,
                                                input logic [TGT_W-1:0] ceil);
      logic [TGT_W-1:0] sum;
      sum = a + b;
      return (sum > ceil) ? ceil : sum;
   endfunction

   // a - b, never below flr. Caller guarantees a >= flr, so a - flr cannot wrap.
   function automatic logic [TGT_W-1:0] sat_sub(input logic [TGT_W-1:0] a,
                                                input logic [TGT_W-1:0] b,
                                                input logic [TGT_W-1:0] flr);
      return ((a - flr) <= b) ? flr : (a - b);
   endfunction

endpackage

// File: rtl/led_pwm_array_channel.sv
// -----------------------------------------------------------------------------
// led_pwm_channel
// One LED channel: duty register, ramp FSM, phase offset and output compare.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   cnt_i          : shared period counter (0..PERIOD-1)
//   step_i         : ramp step strobe, high in the last cycle of a period
//   target_i       : this channel's target duty
//   pwm_o          : registered PWM output, phase < duty
//   ramping_o      : registered, duty differs from target
// PHASE_OFS rotates the phase seen by this channel (0 disables staggering).
// -----------------------------------------------------------------------------
module led_pwm_channel
   import led_pkg::*;
#(
   parameter int unsigned CNT_W     = 10,
   parameter int unsigned PERIOD    = 500,
   parameter int unsigned RAMP_STEP = 5,
   parameter int unsigned PHASE_OFS = 0
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [CNT_W-1:0] cnt_i,
   input  logic             step_i,
   input  logic [CNT_W-1:0] target_i,
   output logic             pwm_o,
   output logic             ramping_o
);

   localparam logic [CNT_W:0]   PERIOD_W = (CNT_W+1)'(PERIOD);
   localparam logic [CNT_W:0]   OFS_W    = (CNT_W+1)'(PHASE_OFS % PERIOD);
   localparam logic [TGT_W-1:0] STEP_W   = TGT_W'(RAMP_STEP);

   ch_state_e        state_q, state_d;
   logic [CNT_W-1:0] duty_q, duty_d;
   logic             pwm_q;
   logic             ramping_q;
   logic [CNT_W:0]   phase_sum_s;
   logic [CNT_W-1:0] phase_s;
   logic [TGT_W-1:0] duty_w_s;
   logic [TGT_W-1:0] tgt_w_s;

   assign duty_w_s = TGT_W'(duty_q);
   assign tgt_w_s  = TGT_W'(target_i);

   // Rotated phase: (counter + offset) mod PERIOD, one subtraction suffices.
   always_comb begin
      phase_sum_s = {1'b0, cnt_i} + OFS_W;
      if (phase_sum_s >= PERIOD_W) begin
         phase_s = CNT_W'(phase_sum_s - PERIOD_W);
      end else begin
         phase_s = phase_sum_s[CNT_W-1:0];
      end
   end

   // Ramp FSM next state: re-derived from (duty, target) at each step strobe.
   always_comb begin
      state_d = state_q;
      duty_d  = duty_q;
      if (step_i) begin
         if (duty_q < target_i) begin
            state_d = CH_UP;
            duty_d  = CNT_W'(sat_add(duty_w_s, STEP_W, tgt_w_s));
         end else if (duty_q > target_i) begin
            state_d = CH_DOWN;
            duty_d  = CNT_W'(sat_sub(duty_w_s, STEP_W, tgt_w_s));
         end else if (duty_q != '0) begin
            state_d = CH_HOLD;
         end else begin
            state_d = CH_IDLE;
         end
      end else begin
         state_d = state_q;
      end
   end

   // Channel registers; the step strobe sits in the last cycle of a period,
   // so a new duty is first compared against phase 0 of the next period.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= CH_IDLE;
         duty_q    <= '0;
         pwm_q     <= 1'b0;
         ramping_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         duty_q    <= duty_d;
         pwm_q     <= (phase_s < duty_q);
         ramping_q <= (duty_d != target_i);
      end
   end

   assign pwm_o     = pwm_q;
   assign ramping_o = ramping_q;

endmodule

// File: rtl/led_pwm_array.sv
// -----------------------------------------------------------------------------
// led_pwm_array
// N_CH-channel LED PWM dimmer sharing one period counter.
//   sys_clk, rst   : clock, synchronous active-high reset
//   mode           : 4'b0001 auto, 4'b0010 manual, others off
//   manual_level   : 0..9 (>=10 treated as 9)
//   light_param    : ambient light, used in auto mode
//   distance       : presence sensor, distance < DIST_TH means occupied
//   ch_enable      : per-channel enable
//   pwm            : registered PWM outputs
//   period_start   : registered pulse, aligned with the pwm sample of counter 0
//   ramping        : per-channel duty != target
// Optional macro LED_STAGGER_EN: channel k phase offset k*(PERIOD/N_CH).
// -----------------------------------------------------------------------------
module led_pwm_array
   import led_pkg::*;
#(
   parameter int unsigned N_CH       = 4,
   parameter int unsigned CNT_W      = 10,
   parameter int unsigned PERIOD     = 500,
   parameter int unsigned DIST_TH    = 100,
   parameter int unsigned AUTO_MAX   = 4500,
   parameter int unsigned AUTO_SHIFT = 3,
   parameter int unsigned RAMP_DIV   = 4,
   parameter int unsigned RAMP_STEP  = 5
) (
   input  logic            sys_clk,
   input  logic            rst,
   input  logic [3:0]      mode,
   input  logic [3:0]      manual_level,
   input  logic [15:0]     light_param,
   input  logic [9:0]      distance,
   input  logic [N_CH-1:0] ch_enable,
   output logic [N_CH-1:0] pwm,
   output logic            period_start,
   output logic [N_CH-1:0] ramping
);

   localparam int unsigned      DIV_W     = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(RAMP_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(PERIOD - 1);
   localparam logic [CNT_W-1:0] PERIOD_C  = CNT_W'(PERIOD);
   localparam logic [TGT_W-1:0] PERIOD_T  = TGT_W'(PERIOD);
   localparam logic [TGT_W-1:0] AUTO_MAX_T = TGT_W'(AUTO_MAX);
   localparam logic [9:0]       DIST_TH_C = 10'(DIST_TH);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic             ps_q;
   logic             wrap_s;
   logic             step_s;
   logic [3:0]       lvl_s;
   logic [TGT_W-1:0] light_w_s;
   logic [TGT_W-1:0] tgt_raw_s;
   logic [CNT_W-1:0] glob_tgt_s;
   logic [TGT_W-1:0] man_tab_s [10];
   logic [CNT_W-1:0] ch_tgt_s [N_CH];

   // Manual duty table, constant after elaboration.
   for (genvar i = 0; i < 10; i++) begin : g_man_tab
      assign man_tab_s[i] = level_to_duty(i, PERIOD);
   end

   assign wrap_s = (cnt_q == CNT_LAST);
   // Every RAMP_DIV-th wrap is a step boundary.
   assign step_s = wrap_s && (div_q == DIV_LAST);

   // Counter and divider next state.
   always_comb begin
      if (wrap_s) begin
         cnt_d = '0;
         div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
         div_d = div_q;
      end
   end

   // Counter, divider and period_start registers.
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         cnt_q <= '0;
         div_q <= '0;
         ps_q  <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         div_q <= div_d;
         ps_q  <= (cnt_q == '0);
      end
   end

   assign period_start = ps_q;

   // Global target from presence, mode, level and ambient light.
   always_comb begin
      lvl_s     = (manual_level > 4'd9) ? 4'd9 : manual_level;
      light_w_s = TGT_W'(light_param);
      tgt_raw_s = '0;
      if (distance >= DIST_TH_C) begin
         tgt_raw_s = '0;
      end else begin
         case (mode)
            MODE_MANUAL: tgt_raw_s = man_tab_s[lvl_s];
            MODE_AUTO: begin
               if (light_w_s >= AUTO_MAX_T) begin
                  tgt_raw_s = '0;
               end else begin
                  tgt_raw_s = (AUTO_MAX_T - light_w_s) >> AUTO_SHIFT;
               end
            end
            default: tgt_raw_s = '0;
         endcase
      end
      glob_tgt_s = (tgt_raw_s > PERIOD_T) ? PERIOD_C : CNT_W'(tgt_raw_s);
   end

   for (genvar k = 0; k < N_CH; k++) begin : g_ch
`ifdef LED_STAGGER_EN
      localparam int unsigned PH_OFS = k * (PERIOD / N_CH);
`else
      localparam int unsigned PH_OFS = 0;
`endif
      assign ch_tgt_s[k] = ch_enable[k] ? glob_tgt_s : '0;

      led_pwm_channel #(
         .CNT_W     (CNT_W),
         .PERIOD    (PERIOD),
         .RAMP_STEP (RAMP_STEP),
         .PHASE_OFS (PH_OFS)
      ) u_ch (
         .clk_i     (sys_clk),
         .rst_i     (rst),
         .cnt_i     (cnt_q),
         .step_i    (step_s),
         .target_i  (ch_tgt_s[k]),
         .pwm_o     (pwm[k]),
         .ramping_o (ramping[k])
      );
   end

endmodule

// File: tb/tb_led_pwm_array.sv
module tb_led_pwm_array;

   localparam int N  = 4;
   localparam int P  = 60;
   localparam int RD = 2;
   localparam int RS = 5;

   logic         sys_clk = 1'b0;
   logic         rst = 1'b1;
   logic [3:0]   mode = 4'b0010;
   logic [3:0]   manual_level = 4'd9;
   logic [15:0]  light_param = 16'd0;
   logic [9:0]   distance = 10'd50;
   logic [N-1:0] ch_enable = 4'hF;
   logic [N-1:0] pwm;
   logic         period_start;
   logic [N-1:0] ramping;

   int n_cmp = 0;
   int n_err = 0;
   int m_duty [N];
   int m_div;
   logic [N-1:0] samp [P];
   logic [N-1:0] ramp_obs;

   led_pwm_array #(
      .N_CH(4), .CNT_W(10), .PERIOD(60), .DIST_TH(100), .AUTO_MAX(4500),
      .AUTO_SHIFT(3), .RAMP_DIV(2), .RAMP_STEP(5)
   ) dut (
      .sys_clk(sys_clk), .rst(rst), .mode(mode), .manual_level(manual_level),
      .light_param(light_param), .distance(distance), .ch_enable(ch_enable),
      .pwm(pwm), .period_start(period_start), .ramping(ramping)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Hand table for PERIOD 60: level*60/9 truncated.
   function automatic int glob_target();
      int lv;
      int a;
      if (distance >= 10'd100) return 0;
      if (mode == 4'b0010) begin
         lv = (manual_level > 4'd9) ? 9 : int'(manual_level);
         case (lv)
            0: return 0;
            1: return 6;
            2: return 13;
            3: return 20;
            4: return 26;
            5: return 33;
            6: return 40;
            7: return 46;
            8: return 53;
            default: return 60;
         endcase
      end
      if (mode == 4'b0001) begin
         if (light_param >= 16'd4500) return 0;
         a = (4500 - int'(light_param)) >> 3;
         return (a > 60) ? 60 : a;
      end
      return 0;
   endfunction

   function automatic int ch_target(input int k);
      return ch_enable[k] ? glob_target() : 0;
   endfunction

   task automatic model_reset();
      m_div = 0;
      for (int k = 0; k < N; k++) m_duty[k] = 0;
   endtask

   // Samples one full pwm period (period_start cycle onward) and checks it.
   task automatic run_period();
      int waited;
      int hi;
      int rise;
      int exp_rise;
      int t;
      waited = 0;
      while (period_start !== 1'b1 && waited < 2 * P) begin
         @(negedge sys_clk);
         waited++;
      end
      check("period_start_sync", int'(period_start), 1);
      for (int j = 0; j < P; j++) begin
         samp[j] = pwm;
         if (j == P / 2) ramp_obs = ramping;
         @(negedge sys_clk);
      end
      for (int k = 0; k < N; k++) begin
         t = ch_target(k);
         hi = 0;
         rise = -1;
         for (int j = 0; j < P; j++) begin
            if (samp[j][k]) hi++;
            if (samp[j][k] && !samp[(j + P - 1) % P][k]) rise = j;
         end
         check($sformatf("high_count_ch%0d", k), hi, m_duty[k]);
         check($sformatf("ramping_ch%0d", k), int'(ramp_obs[k]), (m_duty[k] != t) ? 1 : 0);
         if (m_duty[k] > 0 && m_duty[k] < P) begin
`ifdef LED_STAGGER_EN
            exp_rise = (P - k * (P / N)) % P;
`else
            exp_rise = 0;
`endif
            check($sformatf("rise_pos_ch%0d", k), rise, exp_rise);
         end
      end
      if (m_div == RD - 1) begin
         m_div = 0;
         for (int k = 0; k < N; k++) begin
            t = ch_target(k);
            if (m_duty[k] < t) m_duty[k] = (m_duty[k] + RS > t) ? t : m_duty[k] + RS;
            else if (m_duty[k] > t) m_duty[k] = (m_duty[k] - RS < t) ? t : m_duty[k] - RS;
         end
      end else begin
         m_div++;
      end
   endtask

   task automatic run_periods(input int n);
      for (int i = 0; i < n; i++) run_period();
   endtask

   initial begin
      int guard;
      model_reset();
      repeat (3) @(negedge sys_clk);
      check("rst_pwm", int'(pwm), 0);
      check("rst_ramping", int'(ramping), 0);
      check("rst_period_start", int'(period_start), 0);
      rst = 1'b0;
      @(negedge sys_clk);
      check("first_pulse", int'(period_start), 1);

      // Manual level 9: ramp 0 -> 60, then constant high.
      run_periods(26);

      // Distance exactly at threshold: unoccupied, ramp down to 0.
      distance = 10'd100;
      run_periods(26);

      // Auto mode, just occupied.
      distance = 10'd99;
      mode = 4'b0001;
      light_param = 16'd4300;   // (200>>3)=25
      run_periods(12);
      light_param = 16'd4000;   // 62 saturates to 60
      run_periods(16);
      light_param = 16'd4600;   // above AUTO_MAX -> 0
      run_periods(26);

      // Unassigned mode value is off.
      mode = 4'b0100;
      manual_level = 4'd9;
      run_periods(4);

      // Mid-ramp reversal with a saturated level, then level 2 (13).
      mode = 4'b0010;
      manual_level = 4'd12;
      guard = 0;
      while (m_duty[0] < 30 && guard < 40) begin
         run_period();
         guard++;
      end
      manual_level = 4'd2;
      run_periods(14);

      // Partial enable, then reset mid-ramp.
      manual_level = 4'd6;
      ch_enable = 4'b0101;
      run_periods(6);
      rst = 1'b1;
      @(negedge sys_clk);
      check("midrst_pwm", int'(pwm), 0);
      check("midrst_ramping", int'(ramping), 0);
      check("midrst_period_start", int'(period_start), 0);
      @(negedge sys_clk);
      rst = 1'b0;
      model_reset();
      @(negedge sys_clk);
      check("midrst_first_pulse", int'(period_start), 1);
      run_periods(4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
